// File: rtl/xor_accum_unit.sv
// Registered XOR/XNOR and running XOR-checksum engine with valid/ready handshakes.
// Each accepted beat pushes exactly one result into a DEPTH-entry output FIFO.
module xor_accum_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_parity,
  output logic [CNT_W-1:0] acc_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] MODE_XOR   = 2'b00;
  localparam logic [1:0] MODE_XNOR  = 2'b01;
  localparam logic [1:0] MODE_ACCUM = 2'b10;
  localparam logic [1:0] MODE_RDCLR = 2'b11;

  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_acc_count;
  logic             r_en;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_acc_next;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // r_en keeps in_ready low during reset and until the first edge after release
  assign in_ready  = r_en & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_result   = in_a ^ in_b;
    w_acc_next = r_acc;
    case (in_mode)
      MODE_XOR:   w_result = in_a ^ in_b;
      MODE_XNOR:  w_result = ~(in_a ^ in_b);
      MODE_ACCUM: begin
        w_acc_next = r_acc ^ in_a ^ in_b;
        w_result   = w_acc_next;
      end
      MODE_RDCLR: begin
        w_result   = r_acc;
        w_acc_next = '0;
      end
      default:    w_result = in_a ^ in_b;
    endcase
  end

  // Storage is not reset; the empty gate on out_y hides stale contents
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_result;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_en     <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc       <= '0;
      r_acc_count <= '0;
    end else if (w_push) begin
      r_acc <= w_acc_next;
      if (in_mode == MODE_ACCUM) begin
        if (r_acc_count != CNT_MAX) r_acc_count <= r_acc_count + CNT_W'(1);
      end else if (in_mode == MODE_RDCLR) begin
        r_acc_count <= '0;
      end
    end
  end

  assign out_y      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_parity = ^out_y;
  assign acc_count  = r_acc_count;

endmodule

// File: tb/tb_xor_accum_unit.sv
// Directed self-checking bench for xor_accum_unit (WIDTH=8, DEPTH=4, CNT_W=8).
module tb_xor_accum_unit;

  logic       CLK;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_parity;
  logic [7:0] acc_count;

  int tests;
  int fails;

  xor_accum_unit #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_parity(out_parity),
    .acc_count(acc_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle beat: present inputs, take the edge, then drop in_valid
  task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST_N = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    in_mode = 2'b00;
    out_ready = 1'b1;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_parity", out_parity, 0);
    chk("rst_acc_count", acc_count, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    beat(2'b00, 8'hF0, 8'h3C);
    chk("xor1_valid", out_valid, 1);
    chk("xor1_y", out_y, 8'hCC);
    chk("xor1_par", out_parity, 0);
    beat(2'b00, 8'h01, 8'h00);
    chk("xor2_y", out_y, 8'h01);
    chk("xor2_par", out_parity, 1);
    beat(2'b01, 8'hAA, 8'hAA);
    chk("xnor_y", out_y, 8'hFF);
    chk("xnor_par", out_parity, 0);

    beat(2'b10, 8'h11, 8'h00);
    chk("acc1_y", out_y, 8'h11);
    chk("acc1_cnt", acc_count, 1);
    beat(2'b10, 8'h22, 8'h00);
    chk("acc2_y", out_y, 8'h33);
    beat(2'b10, 8'h44, 8'h00);
    chk("acc3_y", out_y, 8'h77);
    chk("acc3_cnt", acc_count, 3);
    beat(2'b11, 8'hFF, 8'hFF);
    chk("rdclr_y", out_y, 8'h77);
    chk("rdclr_cnt", acc_count, 0);
    beat(2'b10, 8'h05, 8'h00);
    chk("acc4_y", out_y, 8'h05);
    chk("acc4_cnt", acc_count, 1);
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_y", out_y, 0);
    chk("drain_par", out_parity, 0);
    beat(2'b11, 8'h00, 8'h00);
    chk("clr_y", out_y, 8'h05);
    step();
    chk("clr_cnt", acc_count, 0);

    // Backpressure: fill the FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      beat(2'b00, 8'(i), 8'h00);
      chk("bp_in_ready", in_ready, (i < 4) ? 1 : 0);
      chk("bp_head", out_y, 8'h01);
    end
    in_valid = 1'b1;
    in_mode  = 2'b10;
    in_a     = 8'h10;
    in_b     = 8'h00;
    step();
    step();
    chk("bp_hold_cnt", acc_count, 0);
    chk("bp_hold_rdy", in_ready, 0);
    chk("bp_hold_head", out_y, 8'h01);
    out_ready = 1'b1;
    step();
    chk("bp_d1_y", out_y, 8'h02);
    chk("bp_d1_cnt", acc_count, 0);
    chk("bp_d1_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_d2_y", out_y, 8'h03);
    chk("bp_d2_cnt", acc_count, 1);
    step();
    chk("bp_d3_y", out_y, 8'h04);
    step();
    chk("bp_d4_y", out_y, 8'h10);
    step();
    chk("bp_empty", out_valid, 0);

    // Steady push+pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    beat(2'b00, 8'h20, 8'h00);
    beat(2'b00, 8'h21, 8'h00);
    chk("pp_head0", out_y, 8'h20);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      beat(2'b00, 8'(8'h22 + k), 8'h00);
      chk("pp_head", out_y, 8'(8'h21 + k));
      chk("pp_rdy", in_ready, 1);
      chk("pp_valid", out_valid, 1);
    end
    step();
    chk("pp_tail", out_y, 8'h2B);
    step();
    chk("pp_empty", out_valid, 0);

    // Reset mid-stream with three buffered results and acc = 5A
    out_ready = 1'b0;
    beat(2'b11, 8'h00, 8'h00);
    beat(2'b10, 8'h5A, 8'h00);
    beat(2'b00, 8'h01, 8'h01);
    chk("mid_head", out_y, 8'h10);
    chk("mid_cnt", acc_count, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_y", out_y, 0);
    chk("mrst_cnt", acc_count, 0);
    chk("mrst_rdy", in_ready, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("mrel_rdy", in_ready, 1);
    out_ready = 1'b1;
    beat(2'b10, 8'h01, 8'h00);
    chk("post_y", out_y, 8'h01);
    chk("post_cnt", acc_count, 1);
    step();
    chk("post_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xor_accum_unit.md
Name: xor_accum_unit

Overview:
- Parametrised, registered successor to the single-bit XOR gate.
- Performs per-beat bitwise XOR/XNOR on WIDTH-bit operands, or running XOR-checksum accumulation, with valid/ready handshakes on input and output.
- Results are buffered in an internal output FIFO of DEPTH entries so a stalled consumer does not lose data.
- Sits between a stimulus source and a checksum/compare consumer; used as a parity/checksum engine.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- DEPTH, 4, output FIFO entries (power of 2, >=2).
- CNT_W, 8, width of accumulated-beat counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_mode  input  2  00 XOR, 01 XNOR, 10 ACCUM, 11 READ_CLEAR.
- out_valid  output  1  result available at FIFO head.
- out_ready  input  1  consumer takes result.
- out_y  output  WIDTH  result at FIFO head.
- out_parity  output  1  XOR-reduction of out_y.
- acc_count  output  CNT_W  ACCUM beats since last clear, saturating.

Behaviour:
- Reset: RST_N low asynchronously clears the FIFO (rd/wr pointers and count = 0), the accumulator acc = 0 and acc_count = 0.
- Reset output values: out_valid=0, in_ready=0 while RST_N low and 1 from the first edge after release, out_y=0, out_parity=0, acc_count=0.
- Reset mid-operation discards all buffered results and the accumulator.
- Accept: a beat is accepted on a rising edge where in_valid & in_ready. Exactly one result is pushed per accepted beat.
- in_ready = !fifo_full (registered state, not a combinational path from out_ready). A pop in the same cycle does not free a slot for that cycle.
- Result by mode:
  - XOR: in_a ^ in_b; acc unchanged.
  - XNOR: ~(in_a ^ in_b); acc unchanged.
  - ACCUM: acc_next = acc ^ in_a ^ in_b; result = acc_next; acc <= acc_next; acc_count increments, saturating at 2^CNT_W-1.
  - READ_CLEAR: result = current acc (in_a/in_b ignored); acc <= 0; acc_count <= 0.
- Latency: a beat accepted at edge t appears on out_y with out_valid=1 immediately after edge t if the FIFO was empty. Otherwise results emerge in acceptance order.
- Pop: occurs on an edge where out_valid & out_ready. out_y/out_parity always reflect the FIFO head; they are 0 when empty.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Full: count == DEPTH gives in_ready=0. in_valid is ignored, and the mode has no side effect (no acc update).
- Empty: out_valid=0. out_ready is ignored.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Producer must hold in_a/in_b/in_mode stable while in_valid & !in_ready. The unit samples only on acceptance.
- No X propagation: the FIFO storage need not be reset, but out_y is gated to 0 when empty.
- Waveform dump to waves_xor_accum.vcd is produced by the test wrapper, not by this block.

Test Plan:
- Reset then XOR beats with out_ready=1 and WIDTH=8:
  - A=8'hF0,B=8'h3C -> out_y=8'hCC, out_parity=0, one cycle after acceptance.
  - A=8'h01,B=8'h00 -> out_y=8'h01, out_parity=1.
- XNOR: A=8'hAA,B=8'hAA -> out_y=8'hFF, out_parity=0.
- ACCUM sequence:
  - Beats (8'h11,8'h00), (8'h22,8'h00), (8'h44,8'h00) -> out_y 8'h11, 8'h33, 8'h77; acc_count=3.
  - Then READ_CLEAR -> out_y=8'h77, acc_count=0.
  - Then ACCUM (8'h05,8'h00) -> out_y=8'h05.
- Backpressure with out_ready=0:
  - Push 4 XOR beats -> in_ready drops to 0 after 4th acceptance.
  - A 5th ACCUM beat held with in_valid=1 is not accepted: acc_count stays 0.
  - Raise out_ready -> the 4 results drain in order, the 5th beat is then accepted, and no result is lost or duplicated.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2 and output order matches input order, including across pointer wrap.
- Reset mid-stream:
  - Setup: FIFO holding 3 results, acc=8'h5A.
  - Assert RST_N low between edges -> out_valid=0, out_y=0, acc_count=0 immediately.
  - After release, ACCUM (8'h01,8'h00) -> out_y=8'h01.
